// File: rtl/cache_data_pkg.sv
// Shared types, widths and the byte-strobe to bank write-mask helper.
package cache_data_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    localparam int DEF_N_WAYS  = 2;
    localparam int DEF_N_WORDS = 4;
    localparam int DEF_N_SETS  = 32;

    localparam int WORD_W = 32;
    localparam int SET_W  = $clog2(DEF_N_SETS);
    localparam int WAY_W  = (DEF_N_WAYS > 1) ? $clog2(DEF_N_WAYS) : 1;

    // Upper bound on ways the mask helper can describe; callers slice the
    // low WORD_W*N_WAYS bits.
    localparam int MAX_WAYS   = 8;
    localparam int BWEB_MAX_W = WORD_W * MAX_WAYS;

    // Active-low bit write mask: only the strobed bytes of the chosen way
    // are cleared to 0 (written); everything else stays 1 (preserved).
    function automatic logic [BWEB_MAX_W-1:0] strb_to_bweb(
        input logic [3:0] strb,
        input int         way,
        input int         n_ways
    );
        logic [BWEB_MAX_W-1:0] m;
        m = '1;
        for (int k = 0; k < MAX_WAYS; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (k < n_ways && k == way && strb[b])
                    m[WORD_W*k + 8*b +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/cache_data_array_data_bank.sv
// Behavioural single-port SRAM bank: all ways of a set side by side,
// active-low chip/write/bit enables, registered read data.
module data_bank #(
    parameter int N_SETS = 32,
    parameter int DATA_W = 64,
    parameter int A_W    = $clog2(N_SETS)
) (
    input  logic              clk,
    input  logic              ceb,
    input  logic              web,
    input  logic [A_W-1:0]    addr,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] bweb,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [N_SETS];

    // Masked write or registered read; q only changes on a read so it holds
    // the last read word across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (!ceb) begin
            if (!web)
                mem[addr] <= (mem[addr] & bweb) | (d & ~bweb);
            else
                q <= mem[addr];
        end
    end

endmodule

// File: rtl/cache_data_array_ctrl.sv
// N-way cache data array: one bank per word offset, CPU read/byte-write
// port and a critical-word-first line-fill sequencer.
module cache_data_array_ctrl
    import cache_data_pkg::*;
#(
    parameter int N_WAYS  = DEF_N_WAYS,
    parameter int N_WORDS = DEF_N_WORDS,
    parameter int N_SETS  = DEF_N_SETS
) (
    input  logic                             CK,
    input  logic                             RST_N,
    input  logic                             cpu_req_valid,
    output logic                             cpu_req_ready,
    input  logic                             cpu_we,
    input  logic [$clog2(N_SETS)-1:0]        cpu_set,
    input  logic [((N_WAYS > 1) ? $clog2(N_WAYS) : 1)-1:0] cpu_way,
    input  logic [$clog2(N_WORDS)-1:0]       cpu_word,
    input  logic [3:0]                       cpu_wstrb,
    input  logic [31:0]                      cpu_wdata,
    output logic                             cpu_rvalid,
    output logic [32*N_WAYS-1:0]             cpu_rdata,
    input  logic                             fill_start,
    input  logic [$clog2(N_SETS)-1:0]        fill_set,
    input  logic [((N_WAYS > 1) ? $clog2(N_WAYS) : 1)-1:0] fill_way,
    input  logic [$clog2(N_WORDS)-1:0]       fill_first_word,
    input  logic                             fill_valid,
    output logic                             fill_ready,
    input  logic [31:0]                      fill_data,
    input  logic                             fill_last,
    output logic                             fill_done,
    output logic                             fill_err,
    output logic                             busy
);

    localparam int DATA_W = WORD_W * N_WAYS;
    localparam int S_W    = $clog2(N_SETS);
    localparam int W_W    = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam int O_W    = $clog2(N_WORDS);
    localparam int C_W    = O_W + 1;

    fill_state_e state, state_nxt;

    logic [S_W-1:0] set_q;
    logic [W_W-1:0] way_q;
    logic [O_W-1:0] ptr;
    logic [C_W-1:0] cnt;
    logic [C_W-1:0] cnt_nxt;
    logic           err_q;
    logic           rd_ok;
    logic [O_W-1:0] rd_word;

    logic cpu_acc, beat_acc, line_full, beat_end;

    assign cpu_acc   = cpu_req_valid && cpu_req_ready;
    assign beat_acc  = fill_valid && fill_ready;
    assign cnt_nxt   = cnt + 1'b1;
    assign line_full = (cnt_nxt == C_W'(N_WORDS));
    assign beat_end  = beat_acc && (line_full || fill_last);

    // FSM state register
    always_ff @(posedge CK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: fill_start only honoured in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fill_start) state_nxt = FILL;
            FILL:    if (beat_end)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: CPU port is only open in IDLE and yields to fill_start
    always_comb begin
        cpu_req_ready = 1'b0;
        fill_ready    = 1'b0;
        busy          = 1'b0;
        fill_done     = 1'b0;
        fill_err      = 1'b0;
        case (state)
            IDLE: cpu_req_ready = !fill_start;
            FILL: begin
                fill_ready = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                fill_done = 1'b1;
                fill_err  = err_q;
            end
            default: ;
        endcase
    end

    // Fill bookkeeping and read-response tracking
    always_ff @(posedge CK) begin
        if (!RST_N) begin
            set_q      <= '0;
            way_q      <= '0;
            ptr        <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            cpu_rvalid <= 1'b0;
            rd_ok      <= 1'b0;
            rd_word    <= '0;
        end else begin
            cpu_rvalid <= cpu_acc && !cpu_we;
            if (cpu_acc && !cpu_we) begin
                rd_ok   <= 1'b1;
                rd_word <= cpu_word;
            end
            if (state == IDLE && fill_start) begin
                set_q <= fill_set;
                way_q <= fill_way;
                ptr   <= fill_first_word;
                cnt   <= '0;
                err_q <= 1'b0;
            end else if (beat_acc) begin
                // ptr wraps naturally since N_WORDS is a power of two
                ptr <= ptr + 1'b1;
                cnt <= cnt_nxt;
                // error when last and a full line disagree
                if (beat_end) err_q <= (fill_last != line_full);
            end
        end
    end

    // Shared bank write path; CPU and fill accesses are mutually exclusive
    logic [BWEB_MAX_W-1:0] cpu_mask_full, fill_mask_full;
    logic [DATA_W-1:0]     bank_mask, bank_d;
    logic [S_W-1:0]        bank_addr;
    logic                  bank_web;

    assign cpu_mask_full  = strb_to_bweb(cpu_wstrb, int'(cpu_way), N_WAYS);
    assign fill_mask_full = strb_to_bweb(4'hF, int'(way_q), N_WAYS);

    assign bank_mask = beat_acc ? fill_mask_full[DATA_W-1:0] : cpu_mask_full[DATA_W-1:0];
    assign bank_d    = beat_acc ? {N_WAYS{fill_data}} : {N_WAYS{cpu_wdata}};
    assign bank_addr = beat_acc ? set_q : cpu_set;
    assign bank_web  = !(beat_acc || (cpu_acc && cpu_we));

    if (DATA_W < BWEB_MAX_W) begin : g_mask_hi
        logic unused_mask_hi;
        assign unused_mask_hi = &{1'b0, cpu_mask_full[BWEB_MAX_W-1:DATA_W],
                                  fill_mask_full[BWEB_MAX_W-1:DATA_W]};
    end

    logic [DATA_W-1:0] bank_q [N_WORDS];

    for (genvar w = 0; w < N_WORDS; w++) begin : g_bank
        logic ceb;
        assign ceb = !((cpu_acc && cpu_word == O_W'(w)) || (beat_acc && ptr == O_W'(w)));

        data_bank #(.N_SETS(N_SETS), .DATA_W(DATA_W)) u_bank (
            .clk  (CK),
            .ceb  (ceb),
            .web  (bank_web),
            .addr (bank_addr),
            .d    (bank_d),
            .bweb (bank_mask),
            .q    (bank_q[w])
        );
    end

    // Zero until the first read after reset, then the last read bank's data
    assign cpu_rdata = rd_ok ? bank_q[rd_word] : '0;

endmodule

// File: doc/cache_data_array_ctrl.md
Name: cache_data_array_ctrl

Overview:
Parametrised N-way cache data array with an integrated line-fill sequencer. One SRAM bank per word offset, each bank holding all ways of a set side by side. Serves single-word CPU reads and byte-masked writes with 1-cycle read latency. Accepts refill beats from the bus side through a valid/ready handshake, critical-word-first with wrap-around. Sits between the L1 cache controller (tag compare and hit select) and the AXI refill path.

Parameters:
N_WAYS, 2, ways per set (power of 2, >=1)
N_WORDS, 4, 32-bit words per line (power of 2, >=2)
N_SETS, 32, sets per way (power of 2)

Ports:
CK  in  1  clock
RST_N  in  1  synchronous active-low reset
cpu_req_valid  in  1  CPU access request
cpu_req_ready  out  1  request accepted this cycle when valid&&ready
cpu_we  in  1  1=write, 0=read
cpu_set  in  log2(N_SETS)  set index
cpu_way  in  max(1,log2(N_WAYS))  target way (write only)
cpu_word  in  log2(N_WORDS)  word offset
cpu_wstrb  in  4  byte write strobes, bit i = byte i
cpu_wdata  in  32  write data
cpu_rvalid  out  1  read data valid pulse
cpu_rdata  out  32*N_WAYS  addressed word of every way; way k at [32k+31:32k]
fill_start  in  1  begin line refill (IDLE only)
fill_set  in  log2(N_SETS)  refill set
fill_way  in  max(1,log2(N_WAYS))  refill victim way
fill_first_word  in  log2(N_WORDS)  offset of first (critical) beat
fill_valid  in  1  refill beat valid
fill_ready  out  1  beat accepted when valid&&ready
fill_data  in  32  refill beat
fill_last  in  1  final beat marker
fill_done  out  1  one-cycle pulse, refill complete
fill_err  out  1  qualified by fill_done: beat count / last mismatch
busy  out  1  refill in progress

Behaviour:
- Reset (RST_N=0 at posedge): state IDLE; cpu_rvalid, fill_done, fill_err, busy, fill_ready=0; cpu_rdata=0; beat counter and pointer cleared. SRAM contents are not reset.
- States: IDLE, FILL, DONE.
- IDLE: cpu_req_ready = !fill_start.
  - fill_start=1: latch set, way and first_word; pointer=first_word, count=0; go FILL. fill_start wins over a simultaneous CPU request, which is not accepted.
- FILL: busy=1, fill_ready=1, cpu_req_ready=0.
  - Each accepted beat writes all 4 bytes of fill_data to bank[pointer], latched set, latched way only.
  - pointer = (pointer+1) mod N_WORDS, wrapping from N_WORDS-1 to 0. count++.
  - On the beat where count reaches N_WORDS, or fill_last=1: go DONE.
  - fill_err is set when fill_last=1 with count<N_WORDS (early last; remaining words untouched), or when count reaches N_WORDS with fill_last=0.
- DONE: one cycle. fill_done=1, fill_err valid, busy=1, fill_ready=0; then IDLE. Beats presented in DONE are not accepted.
- CPU read accepted at cycle t: all ways of bank[cpu_word] at cpu_set are read; cpu_rvalid=1 and cpu_rdata valid at t+1. cpu_rdata holds until the next accepted read; cpu_rvalid is a single-cycle pulse.
- CPU write: bytes with cpu_wstrb=1 are written in the selected way only; other ways and bytes are unchanged; no response.
  - cpu_wstrb=0 with cpu_we=1 is a no-op that is still accepted.
- Read-after-write to the same address on the next cycle returns the new data.
- Back-to-back reads give one rvalid per cycle.
- A read accepted in the last IDLE cycle before fill_start still delivers rvalid in the following cycle.
- Reset during FILL or DONE: immediate return to IDLE; no fill_done. Words already written remain in the SRAM.
- Bank enable is asserted only on an accepted access or beat. Chip enable and write enable are active-low at the bank boundary.

Decomposition:
- Package cache_data_pkg: typedef fill_state_e {IDLE, FILL, DONE}; localparams WORD_W, SET_W, WAY_W; function strb_to_bweb (4 strobes, way, N_WAYS) returning a 32*N_WAYS active-low bit mask.
- Sub-module data_bank: N_SETS x (32*N_WAYS) single-port behavioural SRAM. Ports: CEB, WEB, active-low BWEB, 1-cycle registered Q. Instantiated N_WORDS times via generate.

Test Plan:
- Reset, then write set 3, way 1, word 2, wdata 0xDEADBEEF, strb 0xF; read the same address next cycle -> rvalid at t+1; rdata[63:32]=0xDEADBEEF; rdata[31:0] unchanged.
- Byte write strb 0b0101, wdata 0x11223344 over 0xAAAAAAAA (set 3, way 0, word 2) -> read returns 0xAA22AA44.
- fill_start set 7, way 0, first_word 2; 4 beats A0..A3 with last on beat 4 -> words 2,3,0,1 = A0,A1,A2,A3; fill_done pulse one cycle after beat 4; fill_err=0; way 1 of set 7 intact.
- fill_last on beat 2 -> fill_done with fill_err=1; only 2 words written. Separately, 4 beats with no last -> fill_err=1.
- fill_start and cpu_req_valid in the same cycle -> cpu_req_ready=0. CPU request stalled through FILL/DONE, accepted in the first IDLE cycle.
- RST_N low after 2 beats -> IDLE next cycle; no fill_done; busy=0; the 2 written words readable.
